// File: rtl/tblink_rpc_invoke_dispatch_if.sv
// Bundles the request, dispatch, response and status signals of the invoke
// dispatcher. "master" is the request-generator / endpoint side and "slave"
// is the dispatcher itself.
interface tblink_rpc_invoke_dispatch_if #(
  parameter int NUM_CHAN  = 4,
  parameter int METHOD_W  = 8,
  parameter int CALL_ID_W = 16,
  parameter int PARAM_W   = 64,
  parameter int CHAN_W    = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1
);
  logic [NUM_CHAN-1:0]           req_valid;
  logic [NUM_CHAN-1:0]           req_ready;
  logic [NUM_CHAN*METHOD_W-1:0]  req_method;
  logic [NUM_CHAN*CALL_ID_W-1:0] req_call_id;
  logic [NUM_CHAN-1:0]           req_blocking;
  logic [NUM_CHAN*PARAM_W-1:0]   req_params;

  logic                          disp_valid;
  logic                          disp_ready;
  logic [CHAN_W-1:0]             disp_chan;
  logic [METHOD_W-1:0]           disp_method;
  logic [CALL_ID_W-1:0]          disp_call_id;
  logic                          disp_blocking;
  logic [PARAM_W-1:0]            disp_params;

  logic                          rsp_valid;
  logic [CHAN_W-1:0]             rsp_chan;

  logic [NUM_CHAN*4-1:0]         outst_cnt;
  logic                          err_rsp;

  modport master (
    output req_valid, req_method, req_call_id, req_blocking, req_params,
    output disp_ready, rsp_valid, rsp_chan,
    input  req_ready, disp_valid, disp_chan, disp_method, disp_call_id,
    input  disp_blocking, disp_params, outst_cnt, err_rsp
  );

  modport slave (
    input  req_valid, req_method, req_call_id, req_blocking, req_params,
    input  disp_ready, rsp_valid, rsp_chan,
    output req_ready, disp_valid, disp_chan, disp_method, disp_call_id,
    output disp_blocking, disp_params, outst_cnt, err_rsp
  );
endinterface

// File: rtl/tblink_rpc_invoke_dispatch.sv
// TbLink RPC invoke dispatcher: per-channel request FIFOs with blocking-call
// credit, drained round-robin into a single registered dispatch port.

// One request channel: FIFO of invoke entries plus its in-flight blocking count.
module tblink_rpc_invoke_chan #(
  parameter int DEPTH     = 4,
  parameter int METHOD_W  = 8,
  parameter int CALL_ID_W = 16,
  parameter int PARAM_W   = 64,
  parameter int MAX_OUTST = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 push,
  input  logic [METHOD_W-1:0]  push_method,
  input  logic [CALL_ID_W-1:0] push_call_id,
  input  logic                 push_blocking,
  input  logic [PARAM_W-1:0]   push_params,
  input  logic                 pop,
  input  logic                 rsp_dec,
  output logic                 ready,
  output logic                 elig,
  output logic [METHOD_W-1:0]  head_method,
  output logic [CALL_ID_W-1:0] head_call_id,
  output logic                 head_blocking,
  output logic [PARAM_W-1:0]   head_params,
  output logic [3:0]           cnt,
  output logic                 dec_err
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [METHOD_W-1:0]  method;
    logic [CALL_ID_W-1:0] call_id;
    logic                 blocking;
    logic [PARAM_W-1:0]   params;
  } ent_t;

  ent_t          mem [DEPTH];
  ent_t          head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          wr_en, cred_inc, cred_dec;

  // Ready depends only on fullness, so a pop never opens a slot the same cycle.
  assign ready    = (count != FULL_CNT);
  assign wr_en    = push & ready;
  assign head     = mem[rd_ptr];
  assign elig     = (count != '0) && (!head.blocking || (cnt < 4'(MAX_OUTST)));
  assign cred_inc = pop & head.blocking;
  assign dec_err  = rsp_dec & (cnt == 4'd0);
  assign cred_dec = rsp_dec & (cnt != 4'd0);

  assign head_method   = head.method;
  assign head_call_id  = head.call_id;
  assign head_blocking = head.blocking;
  assign head_params   = head.params;

  // Entry storage; contents are don't-care while the slot is empty.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr] <= '{method: push_method, call_id: push_call_id,
                                blocking: push_blocking, params: push_params};
  end

  // FIFO pointers/occupancy and the blocking-call credit counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      cnt    <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && !pop)      count <= count + 1'b1;
      else if (!wr_en && pop) count <= count - 1'b1;
      if (cred_inc && !cred_dec)      cnt <= cnt + 4'd1;
      else if (!cred_inc && cred_dec) cnt <= cnt - 4'd1;
    end
  end
endmodule

module tblink_rpc_invoke_dispatch #(
  parameter int NUM_CHAN  = 4,
  parameter int DEPTH     = 4,
  parameter int METHOD_W  = 8,
  parameter int CALL_ID_W = 16,
  parameter int PARAM_W   = 64,
  parameter int MAX_OUTST = 2
) (
  input logic clock,
  input logic reset,
  tblink_rpc_invoke_dispatch_if.slave bus
);
  localparam int CHAN_W = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1;

  logic [NUM_CHAN-1:0]                ready_a, elig_a, pop_a, hit_a, dec_err_a;
  logic [NUM_CHAN-1:0][METHOD_W-1:0]  hd_method;
  logic [NUM_CHAN-1:0][CALL_ID_W-1:0] hd_call_id;
  logic [NUM_CHAN-1:0]                hd_blocking;
  logic [NUM_CHAN-1:0][PARAM_W-1:0]   hd_params;
  logic [NUM_CHAN-1:0][3:0]           cnt_a;

  logic                 load, found, rsp_bad;
  logic [CHAN_W-1:0]    winner, rr_ptr;
  logic                 d_valid, d_blocking, err_q;
  logic [CHAN_W-1:0]    d_chan;
  logic [METHOD_W-1:0]  d_method;
  logic [CALL_ID_W-1:0] d_call_id;
  logic [PARAM_W-1:0]   d_params;

  // Output stage can take a new entry when empty or being handed off.
  assign load    = !d_valid || bus.disp_ready;
  assign rsp_bad = bus.rsp_valid && !(|hit_a);

  for (genvar c = 0; c < NUM_CHAN; c++) begin : g_chan
    assign hit_a[c] = bus.rsp_valid && (bus.rsp_chan == CHAN_W'(c));
    assign pop_a[c] = load && found && (winner == CHAN_W'(c));

    tblink_rpc_invoke_chan #(
      .DEPTH(DEPTH), .METHOD_W(METHOD_W), .CALL_ID_W(CALL_ID_W),
      .PARAM_W(PARAM_W), .MAX_OUTST(MAX_OUTST)
    ) u_chan (
      .clock        (clock),
      .reset        (reset),
      .push         (bus.req_valid[c]),
      .push_method  (bus.req_method[c*METHOD_W +: METHOD_W]),
      .push_call_id (bus.req_call_id[c*CALL_ID_W +: CALL_ID_W]),
      .push_blocking(bus.req_blocking[c]),
      .push_params  (bus.req_params[c*PARAM_W +: PARAM_W]),
      .pop          (pop_a[c]),
      .rsp_dec      (hit_a[c]),
      .ready        (ready_a[c]),
      .elig         (elig_a[c]),
      .head_method  (hd_method[c]),
      .head_call_id (hd_call_id[c]),
      .head_blocking(hd_blocking[c]),
      .head_params  (hd_params[c]),
      .cnt          (cnt_a[c]),
      .dec_err      (dec_err_a[c])
    );
  end

  // Round-robin pick: first eligible channel at or after rr_ptr, wrapping.
  always_comb begin
    int idx;
    idx    = 0;
    found  = 1'b0;
    winner = '0;
    for (int i = 0; i < NUM_CHAN; i++) begin
      idx = (int'(rr_ptr) + i) % NUM_CHAN;
      if (!found && elig_a[idx]) begin
        found  = 1'b1;
        winner = CHAN_W'(idx);
      end
    end
  end

  // Dispatch register, round-robin pointer and sticky response error.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      d_valid    <= 1'b0;
      d_chan     <= '0;
      d_method   <= '0;
      d_call_id  <= '0;
      d_blocking <= 1'b0;
      d_params   <= '0;
      rr_ptr     <= '0;
      err_q      <= 1'b0;
    end else begin
      if (load) begin
        d_valid <= found;
        if (found) begin
          d_chan     <= winner;
          d_method   <= hd_method[winner];
          d_call_id  <= hd_call_id[winner];
          d_blocking <= hd_blocking[winner];
          d_params   <= hd_params[winner];
          rr_ptr     <= (int'(winner) == NUM_CHAN-1) ? '0 : winner + 1'b1;
        end
      end
      err_q <= err_q | rsp_bad | (|dec_err_a);
    end
  end

  assign bus.req_ready     = ready_a;
  assign bus.outst_cnt     = cnt_a;
  assign bus.disp_valid    = d_valid;
  assign bus.disp_chan     = d_chan;
  assign bus.disp_method   = d_method;
  assign bus.disp_call_id  = d_call_id;
  assign bus.disp_blocking = d_blocking;
  assign bus.disp_params   = d_params;
  assign bus.err_rsp       = err_q;
endmodule

// File: tb/tb_tblink_rpc_invoke_dispatch.sv
// Directed bench for the invoke dispatcher: a dispatch-order vector table
// plus hand-written credit, backpressure, simultaneous and error sequences.
module tb_tblink_rpc_invoke_dispatch;
  localparam int NC = 4, DEPTH = 4, MW = 8, CW = 16, PW = 64, MO = 2;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  tblink_rpc_invoke_dispatch_if #(.NUM_CHAN(NC), .METHOD_W(MW), .CALL_ID_W(CW), .PARAM_W(PW)) bus();

  tblink_rpc_invoke_dispatch #(
    .NUM_CHAN(NC), .DEPTH(DEPTH), .METHOD_W(MW), .CALL_ID_W(CW), .PARAM_W(PW), .MAX_OUTST(MO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_err    = 0;

  // One row per cycle: disp_ready to apply, and the dispatch port expected before that edge.
  typedef struct {
    logic        rdy;
    logic        exp_valid;
    logic        chk_data;
    int          exp_chan;
    logic [15:0] exp_id;
  } vec_t;
  vec_t vecs[14];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] cnt_of(input int c);
    return bus.outst_cnt[c*4 +: 4];
  endfunction

  task automatic set_req(input int c, input logic v, input logic blk, input logic [15:0] id);
    bus.req_valid[c]             = v;
    bus.req_blocking[c]          = blk;
    bus.req_call_id[c*CW +: CW]  = id;
    bus.req_method[c*MW +: MW]   = 8'(c + 1);
    bus.req_params[c*PW +: PW]   = {48'h0, id};
  endtask

  task automatic clear_inputs();
    bus.req_valid    = '0;
    bus.req_method   = '0;
    bus.req_call_id  = '0;
    bus.req_blocking = '0;
    bus.req_params   = '0;
    bus.disp_ready   = 1'b0;
    bus.rsp_valid    = 1'b0;
    bus.rsp_chan     = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int waited;
    vecs[0]  = '{1'b1, 1'b1, 1'b1, 0, 16'h00};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 1, 16'h10};
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 1, 16'h10};
    vecs[3]  = '{1'b1, 1'b1, 1'b1, 2, 16'h20};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 3, 16'h30};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 0, 16'h01};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 1, 16'h11};
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 2, 16'h21};
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 3, 16'h31};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 0, 16'h02};
    vecs[10] = '{1'b1, 1'b1, 1'b1, 1, 16'h12};
    vecs[11] = '{1'b1, 1'b1, 1'b1, 2, 16'h22};
    vecs[12] = '{1'b1, 1'b1, 1'b1, 3, 16'h32};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 0, 16'h00};

    // Reset state
    clear_inputs();
    #2 reset = 1'b1;
    #1;
    check("rst_disp_valid", bus.disp_valid, 0);
    check("rst_req_ready", bus.req_ready, 4'hF);
    check("rst_outst", bus.outst_cnt, 16'h0);
    check("rst_err", bus.err_rsp, 0);
    check("rst_call_id", bus.disp_call_id, 0);
    check("rst_params", bus.disp_params, 0);
    tick();
    reset = 1'b0;
    tick();

    // Fairness: preload 3 non-blocking requests on every channel, then drain
    do_reset();
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < NC; c++) set_req(c, 1'b1, 1'b0, 16'(c*16 + k));
      tick();
    end
    for (int c = 0; c < NC; c++) set_req(c, 1'b0, 1'b0, 16'h0);
    tick();
    tick();
    for (int i = 0; i < 14; i++) begin
      bus.disp_ready = vecs[i].rdy;
      check($sformatf("fair%0d_valid", i), bus.disp_valid, vecs[i].exp_valid);
      if (vecs[i].chk_data) begin
        check($sformatf("fair%0d_chan", i), bus.disp_chan, vecs[i].exp_chan);
        check($sformatf("fair%0d_id", i), bus.disp_call_id, vecs[i].exp_id);
      end
      tick();
    end

    // Credit: three blocking calls on chan1, limit of two in flight
    do_reset();
    bus.disp_ready = 1'b1;
    set_req(1, 1'b1, 1'b1, 16'd10);
    tick();
    set_req(1, 1'b1, 1'b1, 16'd11);
    tick();
    check("cred_first_valid", bus.disp_valid, 1);
    check("cred_first_chan", bus.disp_chan, 1);
    check("cred_first_id", bus.disp_call_id, 10);
    check("cred_first_cnt", cnt_of(1), 1);
    set_req(1, 1'b1, 1'b1, 16'd12);
    tick();
    set_req(1, 1'b0, 1'b0, 16'd0);
    check("cred_second_id", bus.disp_call_id, 11);
    check("cred_second_cnt", cnt_of(1), 2);
    tick();
    check("cred_stall_valid", bus.disp_valid, 0);
    tick();
    tick();
    check("cred_stall_valid_late", bus.disp_valid, 0);
    check("cred_stall_cnt", cnt_of(1), 2);
    bus.rsp_valid = 1'b1;
    bus.rsp_chan  = 2'd1;
    tick();
    bus.rsp_valid = 1'b0;
    check("cred_rsp_cnt", cnt_of(1), 1);
    waited = 0;
    while (!bus.disp_valid && waited < 2) begin
      tick();
      waited++;
    end
    check("cred_resume_valid", bus.disp_valid, 1);
    check("cred_resume_id", bus.disp_call_id, 12);
    check("cred_resume_cnt", cnt_of(1), 2);
    check("cred_no_err", bus.err_rsp, 0);

    // Reset mid-traffic takes effect without a clock edge
    set_req(0, 1'b1, 1'b0, 16'h55);
    reset = 1'b1;
    #1;
    check("midrst_disp_valid", bus.disp_valid, 0);
    check("midrst_outst", bus.outst_cnt, 16'h0);
    check("midrst_req_ready", bus.req_ready, 4'hF);
    check("midrst_err", bus.err_rsp, 0);
    clear_inputs();
    tick();
    reset = 1'b0;
    tick();

    // Backpressure: fill chan0 with the output stage stalled
    do_reset();
    for (int k = 0; k < 5; k++) begin
      set_req(0, 1'b1, 1'b0, 16'(100 + k));
      tick();
    end
    set_req(0, 1'b0, 1'b0, 16'd0);
    check("bp_full_ready", bus.req_ready[0], 0);
    check("bp_other_ready", bus.req_ready[3:1], 3'b111);
    check("bp_valid", bus.disp_valid, 1);
    check("bp_id", bus.disp_call_id, 100);
    set_req(0, 1'b1, 1'b0, 16'd105);
    tick();
    tick();
    set_req(0, 1'b0, 1'b0, 16'd0);
    check("bp_hold_valid", bus.disp_valid, 1);
    check("bp_hold_id", bus.disp_call_id, 100);
    check("bp_hold_params", bus.disp_params, 64'd100);
    check("bp_hold_method", bus.disp_method, 8'd1);
    check("bp_hold_ready", bus.req_ready[0], 0);
    bus.disp_ready = 1'b1;
    for (int k = 1; k < 5; k++) begin
      tick();
      check($sformatf("bp_drain%0d_id", k), bus.disp_call_id, 100 + k);
      check($sformatf("bp_drain%0d_valid", k), bus.disp_valid, 1);
      if (k == 1) check("bp_ready_back", bus.req_ready[0], 1);
    end
    tick();
    check("bp_empty_valid", bus.disp_valid, 0);

    // Simultaneous blocking pop and response on chan2
    do_reset();
    bus.disp_ready = 1'b1;
    set_req(2, 1'b1, 1'b1, 16'd20);
    tick();
    set_req(2, 1'b1, 1'b1, 16'd21);
    tick();
    set_req(2, 1'b0, 1'b0, 16'd0);
    check("simul_pre_cnt", cnt_of(2), 1);
    check("simul_pre_id", bus.disp_call_id, 20);
    bus.rsp_valid = 1'b1;
    bus.rsp_chan  = 2'd2;
    tick();
    bus.rsp_valid = 1'b0;
    check("simul_cnt", cnt_of(2), 1);
    check("simul_id", bus.disp_call_id, 21);
    check("simul_blocking", bus.disp_blocking, 1);

    // Response on a channel with nothing outstanding
    check("err_before", bus.err_rsp, 0);
    bus.rsp_valid = 1'b1;
    bus.rsp_chan  = 2'd3;
    tick();
    bus.rsp_valid = 1'b0;
    check("err_set", bus.err_rsp, 1);
    check("err_cnt3", cnt_of(3), 0);
    check("err_cnt2", cnt_of(2), 1);
    tick();
    tick();
    tick();
    check("err_sticky", bus.err_rsp, 1);
    reset = 1'b1;
    #1;
    check("err_cleared", bus.err_rsp, 0);
    tick();
    reset = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
